dtouch_dff: RTL and testbench

Edge-triggered D-type register with complementary outputs. Captures `d` on every rising clock edge and drives `q` together with its bitwise complement `qb`. It is used as the basic storage/flag element in the ticket-seller datapath and control logic. An optional input synchronizer makes it safe for asynchronous inputs.

---
 rtl/dtouch_pkg.sv | 19 +
 rtl/dtouch_sync_stage.sv | 38 +++
 rtl/dtouch_dff.sv | 74 +++++++
 tb/tb_dtouch_dff.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dtouch_pkg.sv
`default_nettype none
// ============================================================================
// Module : dtouch_pkg
// Purpose: Shared constants for the dtouch_dff register and its optional
//          input synchronizer.
// Contents:
//   DTOUCH_DEF_WIDTH    - default data width of the register
//   DTOUCH_SYNC_STAGES  - number of synchronizer flops ahead of the capture flop
//   DTOUCH_DEF_RST_BIT  - default per-bit reset value (replicated to WIDTH)
// Rev    : 1.0  initial release
// ============================================================================
package dtouch_pkg;

  localparam int   DTOUCH_DEF_WIDTH   = 1;
  localparam int   DTOUCH_SYNC_STAGES = 2;
  localparam logic DTOUCH_DEF_RST_BIT = 1'b0;

endpackage : dtouch_pkg
`default_nettype wire

// File: rtl/dtouch_sync_stage.sv
`default_nettype none
// ============================================================================
// Module : dtouch_sync_stage
// Purpose: One WIDTH-bit flop with synchronous active-high reset. Chained to
//          build the optional input synchronizer of dtouch_dff.
// Ports  :
//   clk  in  1      rising-edge clock
//   rst  in  1      synchronous active-high reset, loads RST_VAL
//   d    in  WIDTH  stage input
//   q    out WIDTH  stage output (registered)
// Rev    : 1.0  initial release
// ============================================================================
module dtouch_sync_stage
  import dtouch_pkg::*;
#(
  parameter int               WIDTH   = DTOUCH_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DTOUCH_DEF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : dtouch_sync_stage
`default_nettype wire

// File: rtl/dtouch_dff.sv
`default_nettype none
// ============================================================================
// Module : dtouch_dff
// Purpose: Edge-triggered D register with complementary registered outputs.
//          Optional 2-flop input synchronizer selected by macro DTOUCH_SYNC_EN
//          (latency 3 cycles when defined, 1 cycle otherwise).
// Ports  :
//   clk  in  1      rising-edge clock
//   rst  in  1      synchronous active-high reset; q <= RST_VAL, qb <= ~RST_VAL
//   d    in  WIDTH  data input
//   q    out WIDTH  registered data
//   qb   out WIDTH  registered complement, always ~q
// Rev    : 1.0  initial release
// ============================================================================
module dtouch_dff
  import dtouch_pkg::*;
#(
  parameter int               WIDTH   = DTOUCH_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DTOUCH_DEF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] w_d_cap;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qb;

`ifdef DTOUCH_SYNC_EN
  // w_sync[0] is the raw input; w_sync[i+1] is the output of stage i.
  // Stages clear to RST_VAL so no pre-reset data leaks out after reset.
  logic [WIDTH-1:0] w_sync [0:DTOUCH_SYNC_STAGES];

  assign w_sync[0] = d;

  generate
    for (genvar gi = 0; gi < DTOUCH_SYNC_STAGES; gi++) begin : g_sync
      dtouch_sync_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (w_sync[gi]),
        .q   (w_sync[gi+1])
      );
    end
  endgenerate

  assign w_d_cap = w_sync[DTOUCH_SYNC_STAGES];
`else
  assign w_d_cap = d;
`endif

  // qb is a flop of its own rather than an inverter on q, so both outputs
  // are true register outputs with matched clock-to-out timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= RST_VAL;
      r_qb <= ~RST_VAL;
    end else begin
      r_q  <= w_d_cap;
      r_qb <= ~w_d_cap;
    end
  end

  assign q  = r_q;
  assign qb = r_qb;

endmodule : dtouch_dff
`default_nettype wire

// File: tb/tb_dtouch_dff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dtouch_dff
// Purpose: Self-checking bench for dtouch_dff. Two instances: default
//          (WIDTH=1, reset 0) and WIDTH=4 with RST_VAL=4'hA. A history model
//          predicts q from the sampled inputs; directed steps pin literals.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dtouch_dff;

`ifdef DTOUCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, rst4;
  logic [0:0] d, q, qb;
  logic [3:0] d4, q4, qb4;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  dtouch_dff dut1 (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .qb  (qb)
  );

  dtouch_dff #(.WIDTH(4), .RST_VAL(4'hA)) dut4 (
    .clk (clk),
    .rst (rst4),
    .d   (d4),
    .q   (q4),
    .qb  (qb4)
  );

  task automatic pin(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // After edge k, q equals the reset value if reset was seen on any of the
  // last LAT edges, otherwise the d sampled LAT-1 edges earlier.
  logic [3:0] h_d1 [3];
  logic [3:0] h_d4 [3];
  logic       h_r1 [3];
  logic       h_r4 [3];
  logic       seen1 = 1'b0;
  logic       seen4 = 1'b0;

  always @(posedge clk) begin
    for (int i = 2; i > 0; i--) begin
      h_d1[i] = h_d1[i-1]; h_r1[i] = h_r1[i-1];
      h_d4[i] = h_d4[i-1]; h_r4[i] = h_r4[i-1];
    end
    h_d1[0] = {3'b000, d}; h_r1[0] = rst;
    h_d4[0] = d4;          h_r4[0] = rst4;
    if (rst)  seen1 = 1'b1;
    if (rst4) seen4 = 1'b1;
  end

  always @(negedge clk) begin
    logic       any1, any4;
    logic [3:0] e1, e4;
    any1 = 1'b0; any4 = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any1 |= h_r1[i];
      any4 |= h_r4[i];
    end
    e1 = any1 ? 4'h0 : h_d1[LAT-1];
    e4 = any4 ? 4'hA : h_d4[LAT-1];
    if (seen1) begin
      pin("model_q1",  {3'b000, q},  e1);
      pin("model_qb1", {3'b000, qb}, {3'b000, ~e1[0]});
    end
    if (seen4) begin
      pin("model_q4",  q4,  e4);
      pin("model_qb4", qb4, ~e4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggles every 15 ns starting 2 ns after a falling edge: the toggle
  // times never coincide with a rising edge, so sampling is unambiguous.
  task automatic toggle_run(input int n);
    #2;
    repeat (n) begin
      d  = ~d;
      d4 = 4'($urandom);
      #15;
    end
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1; d = 1'b0; d4 = 4'h0;

    // 1. reset hold with d toggling
    @(negedge clk);
    fork
      toggle_run(4);
      begin
        for (int i = 0; i < 3; i++) begin
          pin("rst_q1",  {3'b000, q},  4'h0);
          pin("rst_qb1", {3'b000, qb}, 4'h1);
          pin("rst_q4",  q4,  4'hA);
          pin("rst_qb4", qb4, 4'h5);
          @(negedge clk);
        end
      end
    join

    // 2. capture
    rst = 1'b0; rst4 = 1'b0; d = 1'b1; d4 = 4'h3;
    tick(LAT);
    pin("cap_q1",  {3'b000, q},  4'h1);
    pin("cap_qb1", {3'b000, qb}, 4'h0);
    pin("cap_q4",  q4,  4'h3);
    pin("cap_qb4", qb4, 4'hC);
    d = 1'b0; d4 = 4'h9;
    tick(LAT);
    pin("cap0_q1",  {3'b000, q},  4'h0);
    pin("cap0_qb1", {3'b000, qb}, 4'h1);
    pin("cap9_q4",  q4,  4'h9);

    // 3. free-running toggles (~20 cycles), checked by the model
    toggle_run(27);
    @(negedge clk);

    // 4. mid-run reset
    d = 1'b1; d4 = 4'h7;
    tick(LAT + 1);
    pin("pre_q1", {3'b000, q}, 4'h1);
    rst = 1'b1; rst4 = 1'b1;
    tick(1);
    pin("mid_q1",  {3'b000, q},  4'h0);
    pin("mid_qb1", {3'b000, qb}, 4'h1);
    pin("mid_q4",  q4,  4'hA);
    rst = 1'b0; rst4 = 1'b0;
    tick(LAT);
    pin("rel_q1", {3'b000, q}, 4'h1);
    pin("rel_q4", q4, 4'h7);

    // 6. glitch rejection: 5 ns pulse well inside a clock period
    d = 1'b0; d4 = 4'h0;
    tick(LAT + 1);
    #3; d = 1'b1; d4 = 4'hF;
    #5; d = 1'b0; d4 = 4'h0;
    tick(LAT + 1);
    pin("glitch_q1", {3'b000, q}, 4'h0);
    pin("glitch_q4", q4, 4'h0);

    // randomized phase with sporadic independent resets
    for (int i = 0; i < 300; i++) begin
      d    = 1'($urandom);
      d4   = 4'($urandom);
      rst  = ($urandom_range(0, 15) == 0);
      rst4 = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    rst = 1'b0; rst4 = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dtouch_dff
`default_nettype wire
